// File: rtl/score_board_mp.sv
// ---------------------------------------------------------------------------
// score_board_mp
// Multi-issue register scoreboard for the MeMIPS issue stage.
//
// Each architectural register has an entry holding a one-hot pipeline
// position (bit STAGES-1 = just issued, bit 0 = writeback) and the tag of the
// pipe that produces the result. Positions shift down one stage on every
// unstalled cycle. Issue logic queries entries to decide whether to forward,
// stall or read the register file.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   stall           freeze all state (no shift, no write)
//   flash           flush: clear every entry at the next edge
//   write_ena       per-port issue write enable            [ISSUE_W]
//   write_addr      destination register per port          [ISSUE_W*AW]
//   write_pos       one-hot initial position per port      [ISSUE_W*STAGES]
//   write_src       producing-pipe tag per port            [ISSUE_W*SRC_W]
//   read_addr       source registers to query              [READ_W*AW]
//   read_pos        current position of queried register   [READ_W*STAGES]
//   read_src        tag of queried entry                   [READ_W*SRC_W]
//   read_busy       entry is in flight                     [READ_W]
//   read_hazard     in flight but not yet forwardable      [READ_W]
//   pending_cnt     registered count of busy registers     [$clog2(NREG+1)]
//
// Optional feature macro: SB_READ_BYPASS_EN
//   When defined, a read that matches an enabled write port in the same
//   (unstalled, unflushed, not-in-reset) cycle sees that port's position and
//   tag combinationally. Without it, reads reflect registered state only.
// ---------------------------------------------------------------------------
module score_board_mp #(
  parameter int NREG       = 32,
  parameter int ISSUE_W    = 2,
  parameter int READ_W     = 4,
  parameter int STAGES     = 4,
  parameter int FWD_STAGES = 2,
  parameter int SRC_W      = 2,
  localparam int AW        = $clog2(NREG),
  localparam int CW        = $clog2(NREG + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flash,
  input  logic [ISSUE_W-1:0]        write_ena,
  input  logic [ISSUE_W*AW-1:0]     write_addr,
  input  logic [ISSUE_W*STAGES-1:0] write_pos,
  input  logic [ISSUE_W*SRC_W-1:0]  write_src,
  input  logic [READ_W*AW-1:0]      read_addr,
  output logic [READ_W*STAGES-1:0]  read_pos,
  output logic [READ_W*SRC_W-1:0]   read_src,
  output logic [READ_W-1:0]         read_busy,
  output logic [READ_W-1:0]         read_hazard,
  output logic [CW-1:0]             pending_cnt
);

  logic [STAGES-1:0] pos_q [NREG];
  logic [SRC_W-1:0]  src_q [NREG];
  logic [STAGES-1:0] pos_n [NREG];
  logic [SRC_W-1:0]  src_n [NREG];
  logic [CW-1:0]     cnt_n;

  // Next-state per entry. Register 0 is skipped so it never records anything.
  // Ports are scanned in ascending order so the highest-index port wins on a
  // collision. The count is taken from the next state so a shift-out and a
  // rewrite of the same register in one cycle stay consistent.
  always_comb begin
    cnt_n = '0;
    for (int i = 0; i < NREG; i++) begin
      pos_n[i] = pos_q[i] >> 1;
      src_n[i] = src_q[i];
      if (i != 0) begin
        for (int p = 0; p < ISSUE_W; p++) begin
          if (write_ena[p] && (write_addr[p*AW +: AW] == AW'(i))) begin
            pos_n[i] = write_pos[p*STAGES +: STAGES];
            src_n[i] = write_src[p*SRC_W +: SRC_W];
          end
        end
      end
      if (|pos_n[i]) begin
        cnt_n = cnt_n + CW'(1);
      end
    end
  end

  // Reset and flush both clear everything; stall holds state and drops writes.
  always_ff @(posedge clk) begin
    if (rst || flash) begin
      for (int i = 0; i < NREG; i++) begin
        pos_q[i] <= '0;
        src_q[i] <= '0;
      end
      pending_cnt <= '0;
    end else if (!stall) begin
      pos_q       <= pos_n;
      src_q       <= src_n;
      pending_cnt <= cnt_n;
    end
  end

  logic [AW-1:0]     rd_addr;
  logic [STAGES-1:0] rd_pos;
  logic [SRC_W-1:0]  rd_src;
  logic              rd_valid;

  // Read ports. Only addresses 1..NREG-1 can match an entry, so r0 and
  // out-of-range addresses fall through to zero without a range compare.
  always_comb begin
    read_pos    = '0;
    read_src    = '0;
    read_busy   = '0;
    read_hazard = '0;
    rd_addr     = '0;
    rd_pos      = '0;
    rd_src      = '0;
    rd_valid    = 1'b0;
    for (int r = 0; r < READ_W; r++) begin
      rd_addr  = read_addr[r*AW +: AW];
      rd_pos   = '0;
      rd_src   = '0;
      rd_valid = 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (rd_addr == AW'(i)) begin
          rd_pos   = pos_q[i];
          rd_src   = src_q[i];
          rd_valid = 1'b1;
        end
      end
`ifdef SB_READ_BYPASS_EN
      if (rd_valid && !rst && !flash && !stall) begin
        for (int p = 0; p < ISSUE_W; p++) begin
          if (write_ena[p] && (write_addr[p*AW +: AW] == rd_addr)) begin
            rd_pos = write_pos[p*STAGES +: STAGES];
            rd_src = write_src[p*SRC_W +: SRC_W];
          end
        end
      end
`else
      rd_valid = rd_valid;
`endif
      read_pos[r*STAGES +: STAGES] = rd_pos;
      read_src[r*SRC_W +: SRC_W]   = rd_src;
      read_busy[r]                 = |rd_pos;
      read_hazard[r]               = (|rd_pos) && !(|rd_pos[FWD_STAGES-1:0]);
    end
  end

endmodule

// File: tb/tb_score_board_mp.sv
// ---------------------------------------------------------------------------
// tb_score_board_mp
// Bench for score_board_mp with default parameters (NREG=32, ISSUE_W=2,
// READ_W=4, STAGES=4, FWD_STAGES=2, SRC_W=2). Inputs change on the falling
// edge; outputs are sampled 1 time unit later. Expected observations are
// queued when stimulus is applied and popped on the cycle they are due.
// Works with or without SB_READ_BYPASS_EN defined.
// ---------------------------------------------------------------------------
module tb_score_board_mp;

  logic        clk = 1'b0;
  logic        rst, stall, flash;
  logic [1:0]  write_ena;
  logic [9:0]  write_addr;
  logic [7:0]  write_pos;
  logic [3:0]  write_src;
  logic [19:0] read_addr;
  logic [15:0] read_pos;
  logic [7:0]  read_src;
  logic [3:0]  read_busy;
  logic [3:0]  read_hazard;
  logic [5:0]  pending_cnt;

  score_board_mp dut (
    .clk(clk), .rst(rst), .stall(stall), .flash(flash),
    .write_ena(write_ena), .write_addr(write_addr), .write_pos(write_pos),
    .write_src(write_src), .read_addr(read_addr), .read_pos(read_pos),
    .read_src(read_src), .read_busy(read_busy), .read_hazard(read_hazard),
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  // Observation layout: {pos[3:0], src[1:0], busy, hazard, cnt[5:0]}
  typedef struct {
    string       name;
    int          cyc;
    int          port;
    logic [13:0] value;
    logic [13:0] mask;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [13:0] got;
  int checks = 0;
  int errors = 0;

  localparam logic [13:0] ALL    = 14'h3fff;
  localparam logic [13:0] NO_SRC = 14'b1111_00_11_111111;

  function automatic logic [13:0] observe(input int port);
    return {read_pos[port*4 +: 4], read_src[port*2 +: 2], read_busy[port],
            read_hazard[port], pending_cnt};
  endfunction

  function automatic exp_t mk(input string name, input int cyc, input int port,
                              input logic [3:0] pos, input logic [1:0] src,
                              input logic busy, input logic haz,
                              input logic [5:0] cnt, input logic src_care);
    exp_t x;
    x.name  = name;
    x.cyc   = cyc;
    x.port  = port;
    x.value = {pos, src, busy, haz, cnt};
    x.mask  = src_care ? ALL : NO_SRC;
    return x;
  endfunction

  task automatic idle();
    rst = 1'b0; stall = 1'b0; flash = 1'b0;
    write_ena = 2'b00; write_addr = '0; write_pos = '0; write_src = '0;
  endtask

  task automatic drain();
    idle();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] a [4];
    rst = 1'b1; stall = 1'b0; flash = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) a[i] = 5'($urandom_range(1, 31));
      write_ena  = 2'b11;
      write_addr = {a[1], a[0]};
      write_pos  = 8'b1000_0100;
      write_src  = 4'($urandom);
      read_addr  = {a[3], a[2], a[1], a[0]};
    end
    @(negedge clk);
    idle();
    for (int i = 0; i < 4; i++) sb.push_back(mk("reset_clear", 0, i, 4'b0, 2'b0, 1'b0, 1'b0, 6'd0, 1'b1));
    #1;
    while (sb.size() > 0 && sb[0].cyc == 0) begin
      e = sb.pop_front(); got = observe(e.port); checks++;
      if ((got & e.mask) !== (e.value & e.mask)) begin
        errors++;
        $display("[TB] FAIL %s cyc%0d port%0d got %b expected %b", e.name, e.cyc, e.port, got, e.value);
      end
    end
    // Live entries must also be cleared by reset.
    write_ena  = 2'b11;
    write_addr = {5'd8, 5'd4};
    write_pos  = 8'b1000_1000;
    write_src  = 4'b0110;
    read_addr  = {5'd0, 5'd0, 5'd8, 5'd4};
    sb.push_back(mk("pre_reset_live", 1, 0, 4'b1000, 2'b10, 1'b1, 1'b1, 6'd2, 1'b1));
    sb.push_back(mk("reset_live_r4", 4, 0, 4'b0, 2'b0, 1'b0, 1'b0, 6'd0, 1'b1));
    sb.push_back(mk("reset_live_r8", 4, 1, 4'b0, 2'b0, 1'b0, 1'b0, 6'd0, 1'b1));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      write_ena = 2'b00;
      if (k == 2 || k == 3) begin
        rst = 1'b1;
        write_ena  = 2'b11;
        write_addr = {5'd8, 5'd4};
      end else begin
        rst = 1'b0;
      end
      #1;
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); got = observe(e.port); checks++;
        if ((got & e.mask) !== (e.value & e.mask)) begin
          errors++;
          $display("[TB] FAIL %s cyc%0d port%0d got %b expected %b", e.name, e.cyc, e.port, got, e.value);
        end
      end
    end
    idle();
  endtask

  task automatic test_shift();
    drain();
    @(negedge clk);
    write_ena = 2'b01; write_addr = {5'd0, 5'd5}; write_pos = 8'b0000_1000; write_src = 4'b0001;
    read_addr = {5'd0, 5'd0, 5'd0, 5'd5};
    sb.push_back(mk("shift_1000", 1, 0, 4'b1000, 2'b01, 1'b1, 1'b1, 6'd1, 1'b1));
    sb.push_back(mk("shift_0100", 2, 0, 4'b0100, 2'b01, 1'b1, 1'b1, 6'd1, 1'b1));
    sb.push_back(mk("shift_0010", 3, 0, 4'b0010, 2'b01, 1'b1, 1'b0, 6'd1, 1'b1));
    sb.push_back(mk("shift_0001", 4, 0, 4'b0001, 2'b01, 1'b1, 1'b0, 6'd1, 1'b1));
    sb.push_back(mk("shift_free", 5, 0, 4'b0000, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      idle();
      #1;
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); got = observe(e.port); checks++;
        if ((got & e.mask) !== (e.value & e.mask)) begin
          errors++;
          $display("[TB] FAIL %s cyc%0d port%0d got %b expected %b", e.name, e.cyc, e.port, got, e.value);
        end
      end
    end
  endtask

  task automatic test_collision();
    drain();
    @(negedge clk);
    write_ena = 2'b11; write_addr = {5'd7, 5'd7}; write_pos = 8'b0100_1000; write_src = 4'b1000;
    read_addr = {5'd0, 5'd0, 5'd7, 5'd0};
    sb.push_back(mk("collision_win", 1, 1, 4'b0100, 2'b10, 1'b1, 1'b1, 6'd1, 1'b1));
    sb.push_back(mk("collision_drain", 4, 1, 4'b0000, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      idle();
      #1;
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); got = observe(e.port); checks++;
        if ((got & e.mask) !== (e.value & e.mask)) begin
          errors++;
          $display("[TB] FAIL %s cyc%0d port%0d got %b expected %b", e.name, e.cyc, e.port, got, e.value);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    drain();
    @(negedge clk);
    write_ena = 2'b11; write_addr = {5'd11, 5'd10}; write_pos = 8'b1000_0010; write_src = 4'b0111;
    read_addr = {5'd11, 5'd10, 5'd0, 5'd0};
    sb.push_back(mk("b2b_r10", 1, 2, 4'b0010, 2'b11, 1'b1, 1'b0, 6'd2, 1'b1));
    sb.push_back(mk("b2b_r11", 1, 3, 4'b1000, 2'b01, 1'b1, 1'b1, 6'd2, 1'b1));
    sb.push_back(mk("b2b_r10", 2, 2, 4'b0001, 2'b11, 1'b1, 1'b0, 6'd2, 1'b1));
    sb.push_back(mk("b2b_r11", 2, 3, 4'b0100, 2'b01, 1'b1, 1'b1, 6'd2, 1'b1));
    sb.push_back(mk("b2b_rewrite_r10", 3, 2, 4'b0100, 2'b00, 1'b1, 1'b1, 6'd2, 1'b1));
    sb.push_back(mk("b2b_r11", 3, 3, 4'b0010, 2'b01, 1'b1, 1'b0, 6'd2, 1'b1));
    sb.push_back(mk("b2b_r10", 4, 2, 4'b0010, 2'b00, 1'b1, 1'b0, 6'd2, 1'b1));
    sb.push_back(mk("b2b_r11", 4, 3, 4'b0001, 2'b01, 1'b1, 1'b0, 6'd2, 1'b1));
    sb.push_back(mk("b2b_r10", 5, 2, 4'b0001, 2'b00, 1'b1, 1'b0, 6'd1, 1'b1));
    sb.push_back(mk("b2b_r11_free", 5, 3, 4'b0000, 2'b00, 1'b0, 1'b0, 6'd1, 1'b0));
    sb.push_back(mk("b2b_r10_free", 6, 2, 4'b0000, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      idle();
      #1;
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); got = observe(e.port); checks++;
        if ((got & e.mask) !== (e.value & e.mask)) begin
          errors++;
          $display("[TB] FAIL %s cyc%0d port%0d got %b expected %b", e.name, e.cyc, e.port, got, e.value);
        end
      end
      // r10 is leaving the pipe this cycle; rewrite it on the same edge.
      if (k == 2) begin
        write_ena = 2'b01; write_addr = {5'd0, 5'd10}; write_pos = 8'b0000_0100; write_src = 4'b0000;
      end
    end
  endtask

  task automatic test_stall_flush();
    drain();
    @(negedge clk);
    write_ena = 2'b01; write_addr = {5'd0, 5'd3}; write_pos = 8'b0000_0100; write_src = 4'b0010;
    read_addr = {5'd0, 5'd0, 5'd9, 5'd3};
    for (int k = 1; k <= 4; k++) begin
      sb.push_back(mk("stall_hold_r3", k, 0, 4'b0100, 2'b10, 1'b1, 1'b1, 6'd1, 1'b1));
      sb.push_back(mk("stall_drop_r9", k, 1, 4'b0000, 2'b00, 1'b0, 1'b0, 6'd1, 1'b0));
    end
    sb.push_back(mk("flush_r3", 5, 0, 4'b0000, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0));
    sb.push_back(mk("flush_r9", 5, 1, 4'b0000, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) begin
        stall = 1'b1;
        write_ena = 2'b01; write_addr = {5'd0, 5'd9}; write_pos = 8'b0000_1000; write_src = 4'b0001;
      end else begin
        idle();
      end
      #1;
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); got = observe(e.port); checks++;
        if ((got & e.mask) !== (e.value & e.mask)) begin
          errors++;
          $display("[TB] FAIL %s cyc%0d port%0d got %b expected %b", e.name, e.cyc, e.port, got, e.value);
        end
      end
      if (k == 4) flash = 1'b1;
    end
  endtask

  task automatic test_r0();
    drain();
    @(negedge clk);
    write_ena = 2'b01; write_addr = {5'd0, 5'd20}; write_pos = 8'b0000_1000; write_src = 4'b0001;
    read_addr = {5'd0, 5'd20, 5'd0, 5'd0};
    sb.push_back(mk("r0_same_cycle", 1, 0, 4'b0000, 2'b00, 1'b0, 1'b0, 6'd1, 1'b1));
    sb.push_back(mk("r0_live_r20", 1, 2, 4'b1000, 2'b01, 1'b1, 1'b1, 6'd1, 1'b1));
    sb.push_back(mk("r0_next_cycle", 2, 1, 4'b0000, 2'b00, 1'b0, 1'b0, 6'd1, 1'b1));
    sb.push_back(mk("r0_live_r20", 2, 2, 4'b0100, 2'b01, 1'b1, 1'b1, 6'd1, 1'b1));
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        write_ena = 2'b01; write_addr = {5'd0, 5'd0}; write_pos = 8'b0000_1000; write_src = 4'b0011;
      end else begin
        idle();
      end
      #1;
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); got = observe(e.port); checks++;
        if ((got & e.mask) !== (e.value & e.mask)) begin
          errors++;
          $display("[TB] FAIL %s cyc%0d port%0d got %b expected %b", e.name, e.cyc, e.port, got, e.value);
        end
      end
    end
  endtask

  task automatic test_bypass();
    drain();
    @(negedge clk);
    write_ena = 2'b10; write_addr = {5'd12, 5'd0}; write_pos = 8'b1000_0000; write_src = 4'b0100;
    read_addr = {5'd12, 5'd0, 5'd0, 5'd0};
`ifdef SB_READ_BYPASS_EN
    sb.push_back(mk("bypass_same_cycle", 0, 3, 4'b1000, 2'b01, 1'b1, 1'b1, 6'd0, 1'b1));
`else
    sb.push_back(mk("no_bypass_same_cycle", 0, 3, 4'b0000, 2'b00, 1'b0, 1'b0, 6'd0, 1'b0));
`endif
    sb.push_back(mk("bypass_next_cycle", 1, 3, 4'b1000, 2'b01, 1'b1, 1'b1, 6'd1, 1'b1));
    for (int k = 0; k <= 1; k++) begin
      if (k == 1) begin
        @(negedge clk);
        idle();
      end
      #1;
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); got = observe(e.port); checks++;
        if ((got & e.mask) !== (e.value & e.mask)) begin
          errors++;
          $display("[TB] FAIL %s cyc%0d port%0d got %b expected %b", e.name, e.cyc, e.port, got, e.value);
        end
      end
    end
  endtask

  initial begin
    idle();
    read_addr = '0;
    test_reset();
    test_shift();
    test_collision();
    test_back_to_back();
    test_stall_flush();
    test_r0();
    test_bypass();
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
